// File: rtl/fft_pkg.sv
//----------------------------------------------------------------------------
// fft_pkg : shared constants, complex sample type and bit-reverse helper
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

package fft_pkg;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 23;
  localparam int N      = 8;
  localparam int LOG2N  = 3;

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_t;

  // Reverse the low 'width' bits of idx; upper bits of the result are zero.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned width);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < width; b++) begin
      r = (r << 1) | ((idx >> b) & 32'd1);
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_pp_bank.sv
//----------------------------------------------------------------------------
// fft_pp_bank : N-lane complex register bank with single-lane write decode
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fft_pp_bank #(
  parameter int DATA_W = 32,
  parameter int N      = 8,
  parameter int LOG2N  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [LOG2N-1:0]    wr_lane,
  input  logic [DATA_W-1:0]   wr_real,
  input  logic [DATA_W-1:0]   wr_imag,
  output logic [N*DATA_W-1:0] rd_real,
  output logic [N*DATA_W-1:0] rd_imag
);

  for (genvar j = 0; j < N; j++) begin : g_lane
    logic [DATA_W-1:0] lane_re;
    logic [DATA_W-1:0] lane_im;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lane_re <= '0;
        lane_im <= '0;
      end else if (wr_en && (wr_lane == LOG2N'(j))) begin
        lane_re <= wr_real;
        lane_im <= wr_imag;
      end
    end

    assign rd_real[j*DATA_W +: DATA_W] = lane_re;
    assign rd_imag[j*DATA_W +: DATA_W] = lane_im;
  end

endmodule

`default_nettype wire

// File: rtl/fft_in_reorder.sv
//----------------------------------------------------------------------------
// fft_in_reorder : natural-order sample stream -> bit-reversed N-lane frames
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module fft_in_reorder
  import fft_pkg::bitrev;
#(
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int N      = fft_pkg::N,
  parameter int LOG2N  = fft_pkg::LOG2N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_last,
  input  logic [DATA_W-1:0]   in_real,
  input  logic [DATA_W-1:0]   in_imag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N*DATA_W-1:0] out_real,
  output logic [N*DATA_W-1:0] out_imag,
  output logic                frame_err
);

  logic [1:0]          full;
  logic                wr_bank;
  logic                rd_bank;
  logic [LOG2N-1:0]    wr_idx;

  logic                accept;
  logic                last_idx;
  logic                complete;
  logic                drop;
  logic                consume;
  logic                sel;
  logic [LOG2N-1:0]    wr_lane;
  logic [N*DATA_W-1:0] bank_real [2];
  logic [N*DATA_W-1:0] bank_imag [2];

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid & in_ready;
  assign last_idx = (wr_idx == LOG2N'(N-1));
  assign complete = accept & last_idx;
  assign drop     = accept & in_last & !last_idx;
  assign consume  = out_valid & out_ready;
  assign wr_lane  = LOG2N'(bitrev(32'(wr_idx), LOG2N));

  // On consume the output register looks ahead to the other bank so a
  // waiting frame follows with no bubble.
  assign sel = consume ? ~rd_bank : rd_bank;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_pp_bank #(
      .DATA_W (DATA_W),
      .N      (N),
      .LOG2N  (LOG2N)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (accept & !drop & (wr_bank == 1'(b))),
      .wr_lane (wr_lane),
      .wr_real (in_real),
      .wr_imag (in_imag),
      .rd_real (bank_real[b]),
      .rd_imag (bank_imag[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      frame_err <= 1'b0;
    end else begin
      // consume and complete always target different banks
      if (consume) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
      if (complete) begin
        full[wr_bank] <= 1'b1;
        wr_bank       <= ~wr_bank;
      end

      if (complete || drop) begin
        wr_idx <= '0;
      end else if (accept) begin
        wr_idx <= wr_idx + LOG2N'(1);
      end

      frame_err <= (complete & !in_last) | drop;

      out_valid <= full[sel];
      out_real  <= full[sel] ? bank_real[sel] : '0;
      out_imag  <= full[sel] ? bank_imag[sel] : '0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fft_in_reorder.sv
//----------------------------------------------------------------------------
// tb_fft_in_reorder : directed table, corner sequences and random scoreboard
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_fft_in_reorder;

  localparam int DW = 32;
  localparam int NN = 8;
  localparam int LG = 3;

  typedef logic [NN*DW-1:0] lanes_t;
  typedef struct packed { lanes_t re; lanes_t im; } frm_t;
  typedef struct packed {
    logic [7:0][31:0] re;
    logic [7:0][31:0] exp_lane;
    logic signed [7:0] last_at;
    logic             exp_err;
    logic             exp_frame;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_last;
  logic [DW-1:0] in_real, in_imag;
  logic          out_valid, out_ready, frame_err;
  lanes_t        out_real, out_imag;

  always #5 clk = ~clk;

  fft_in_reorder #(.DATA_W(DW), .N(NN), .LOG2N(LG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .frame_err (frame_err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  frm_t       sbq[$];
  logic [DW-1:0] m_re[NN];
  logic [DW-1:0] m_im[NN];
  int         m_idx = 0;
  int         frames_done = 0;
  int         cyc = 0;
  int         cons_cyc[$];
  bit         last_acc;
  vec_t       tbl[5];

  function automatic int brev3(input int i);
    logic [2:0] b;
    b = 3'(i);
    return int'({b[0], b[1], b[2]});
  endfunction

  function automatic logic [7:0][31:0] pk8(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0000;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(input string name, input lanes_t act, input lanes_t exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: sample handshakes before the edge, update model after it.
  task automatic tick();
    bit     acc, cons, exp_err;
    lanes_t ore, oim;
    frm_t   e, f;
    acc  = in_valid & in_ready;
    cons = out_valid & out_ready;
    ore  = out_real;
    oim  = out_imag;
    @(posedge clk);
    #1;
    cyc++;
    exp_err = 1'b0;
    if (cons) begin
      cons_cyc.push_back(cyc);
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_frame: got %h expected none", ore);
      end else begin
        e = sbq.pop_front();
        chk("frame_real", ore, e.re);
        chk("frame_imag", oim, e.im);
      end
    end
    if (acc) begin
      if (m_idx == NN-1) begin
        m_re[m_idx] = in_real;
        m_im[m_idx] = in_imag;
        for (int j = 0; j < NN; j++) begin
          f.re[j*DW +: DW] = m_re[brev3(j)];
          f.im[j*DW +: DW] = m_im[brev3(j)];
        end
        sbq.push_back(f);
        frames_done++;
        m_idx   = 0;
        exp_err = !in_last;
      end else if (in_last) begin
        m_idx   = 0;
        exp_err = 1'b1;
      end else begin
        m_re[m_idx] = in_real;
        m_im[m_idx] = in_imag;
        m_idx++;
      end
    end
    chk("frame_err", lanes_t'(frame_err), lanes_t'(exp_err));
    last_acc = acc;
  endtask

  task automatic send(input logic [31:0] re, input logic [31:0] im, input bit last);
    in_valid = 1'b1;
    in_real  = re;
    in_imag  = im;
    in_last  = last;
    for (int w = 0; w < 100; w++) begin
      tick();
      if (last_acc) break;
    end
    if (!last_acc) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got in_ready=0 expected accept within 100 cycles");
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", lanes_t'(out_valid), '0);
    chk("rst_real", out_real, '0);
    chk("rst_imag", out_imag, '0);
    chk("rst_err", lanes_t'(frame_err), '0);
    sbq.delete();
    m_idx    = 0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t expim, held;
    vec_t   v;
    int     n, target;

    rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_real = '0; in_imag = '0; out_ready = 1'b0;
    #1;
    chk("reset_valid", lanes_t'(out_valid), '0);
    chk("reset_in_ready", lanes_t'(in_ready), lanes_t'(1));
    chk("reset_real", out_real, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    tbl[0] = '{re: pk8(1, 2, 3, 4, 5, 6, 7, 8), exp_lane: pk8(1, 5, 3, 7, 2, 6, 4, 8),
               last_at: 8'sd7, exp_err: 1'b0, exp_frame: 1'b1};
    tbl[1] = '{re: pk8(1, 2, 3, 4, 5, 0, 0, 0), exp_lane: '0,
               last_at: 8'sd4, exp_err: 1'b1, exp_frame: 1'b0};
    tbl[2] = '{re: pk8(10, 11, 12, 13, 14, 15, 16, 17), exp_lane: pk8(10, 14, 12, 16, 11, 15, 13, 17),
               last_at: 8'sd7, exp_err: 1'b0, exp_frame: 1'b1};
    tbl[3] = '{re: pk8(100, 101, 102, 103, 104, 105, 106, 107),
               exp_lane: pk8(100, 104, 102, 106, 101, 105, 103, 107),
               last_at: -8'sd1, exp_err: 1'b1, exp_frame: 1'b1};
    tbl[4] = '{re: pk8(32'h7FFF_FFFF, 32'h8000_0000, 0, 32'hFFFF_FFFF, 1, 2, 3, 4),
               exp_lane: pk8(32'h7FFF_FFFF, 1, 0, 3, 32'h8000_0000, 2, 32'hFFFF_FFFF, 4),
               last_at: 8'sd7, exp_err: 1'b0, exp_frame: 1'b1};

    // Table: single frames, framing errors, bit-exact extremes
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v = tbl[i];
      n = (v.last_at >= 0 && v.last_at < 7) ? int'(v.last_at) + 1 : 8;
      for (int k = 0; k < n; k++) begin
        send(v.re[k], -v.re[k], (k == int'(v.last_at)));
      end
      chk("lat0_valid", lanes_t'(out_valid), '0);
      chk("err_pulse", lanes_t'(frame_err), lanes_t'(v.exp_err));
      tick();
      chk("lat1_valid", lanes_t'(out_valid), lanes_t'(v.exp_frame));
      chk("err_one_cycle", lanes_t'(frame_err), '0);
      if (v.exp_frame) begin
        for (int j = 0; j < NN; j++) expim[j*DW +: DW] = -v.exp_lane[j];
        chk("lanes_real", out_real, v.exp_lane);
        chk("lanes_imag", out_imag, expim);
      end
      repeat (4) tick();
    end

    // Back-to-back frames with no input stall
    cons_cyc.delete();
    for (int k = 0; k < 24; k++) begin
      in_valid = 1'b1;
      in_real  = DW'(200 + k);
      in_imag  = -DW'(200 + k);
      in_last  = (k % 8 == 7);
      chk("t2_in_ready", lanes_t'(in_ready), lanes_t'(1));
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) tick();
    chk("t2_frames", lanes_t'(cons_cyc.size()), lanes_t'(3));
    if (cons_cyc.size() == 3) begin
      chk("t2_gap1", lanes_t'(cons_cyc[1] - cons_cyc[0]), lanes_t'(8));
      chk("t2_gap2", lanes_t'(cons_cyc[2] - cons_cyc[1]), lanes_t'(8));
    end

    // Downstream stall: both banks fill, then release one cycle
    out_ready = 1'b0;
    held = '0;
    for (int k = 0; k < 16; k++) begin
      send(DW'(300 + k), -DW'(300 + k), (k % 8 == 7));
      if (k == 9) held = out_real;
    end
    chk("t3_frame1", out_real, pk8(300, 304, 302, 306, 301, 305, 303, 307));
    chk("t3_valid", lanes_t'(out_valid), lanes_t'(1));
    chk("t3_in_ready_low", lanes_t'(in_ready), '0);
    in_valid = 1'b1; in_real = DW'(316); in_imag = -DW'(316); in_last = 1'b0;
    repeat (3) begin
      tick();
      chk("t3_blocked", lanes_t'(last_acc), '0);
      chk("t3_hold", out_real, held);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_frame2_valid", lanes_t'(out_valid), lanes_t'(1));
    chk("t3_frame2", out_real, pk8(308, 312, 310, 314, 309, 313, 311, 315));
    chk("t3_ready_back", lanes_t'(in_ready), lanes_t'(1));
    for (int k = 16; k < 24; k++) send(DW'(300 + k), -DW'(300 + k), (k == 23));
    out_ready = 1'b1;
    repeat (6) tick();
    chk("t3_drained", lanes_t'(sbq.size()), '0);

    // Reset mid-frame, then reset during a stall
    for (int k = 0; k < 5; k++) send(DW'(400 + k), -DW'(400 + k), 1'b0);
    do_reset();
    repeat (3) tick();
    chk("t5_no_out_a", lanes_t'(out_valid), '0);
    out_ready = 1'b0;
    for (int k = 0; k < 11; k++) send(DW'(500 + k), -DW'(500 + k), (k == 7));
    chk("t5_stall_valid", lanes_t'(out_valid), lanes_t'(1));
    do_reset();
    chk("t5_in_ready", lanes_t'(in_ready), lanes_t'(1));
    repeat (3) tick();
    chk("t5_no_out_b", lanes_t'(out_valid), '0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) send(DW'(600 + k), -DW'(600 + k), (k == 7));
    repeat (4) tick();
    chk("t5_fresh_frame", lanes_t'(sbq.size()), '0);

    // Random handshakes on both sides, extreme values
    target = frames_done + 1000;
    for (int c = 0; c < 60000 && frames_done < target; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_real   = pick();
      in_imag   = pick();
      in_last   = (m_idx == NN-1);
      tick();
    end
    chk("t6_frames", lanes_t'(frames_done >= target), lanes_t'(1));
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && sbq.size() != 0; c++) tick();
    tick();
    chk("t6_drained", lanes_t'(sbq.size()), '0);
    chk("t6_idle", lanes_t'(out_valid), '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
